// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Captures a packed result matrix in one cycle and streams it out one
//   element per valid/ready transfer. Order is row-major and each element
//   carries its row/column index and a last flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   res_in     packed matrix, MSB-first row-major (element (0,0) in top bits)
//   load       capture res_in and start streaming (honoured only when idle)
//   busy       high while a matrix is held or streaming (STREAM and DONE)
//   out_data   current element
//   out_valid  out_data/out_row/out_col/out_last are valid
//   out_ready  sink accepts the current element this cycle
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   high with the final element (rRow-1, rCol-1)
//   done       one-cycle pulse after the final transfer
module matrix_result_streamer #(
  parameter int rRow       = 4,
  parameter int rCol       = 2,
  parameter int elemWidth  = 8,
  parameter int matrixRLen = 64,
  parameter int idxWidth   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [matrixRLen-1:0] res_in,
  input  logic                  load,
  output logic                  busy,
  output logic [elemWidth-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [idxWidth-1:0]   out_row,
  output logic [idxWidth-1:0]   out_col,
  output logic                  out_last,
  output logic                  done
);

  localparam int unsigned NELEM = rRow * rCol;
  localparam int unsigned NCOL  = rCol;
  localparam int unsigned EW    = elemWidth;
  localparam logic [idxWidth-1:0] LAST_ROW = idxWidth'(rRow - 1);
  localparam logic [idxWidth-1:0] LAST_COL = idxWidth'(rCol - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                  state_q;
  logic [matrixRLen-1:0]   shadow_q;
  logic [idxWidth-1:0]     row_q, col_q;
  logic [idxWidth-1:0]     row_d, col_d;
  logic [elemWidth-1:0]    data_q, data_d;
  logic                    valid_q, busy_q, done_q;
  logic                    xfer;
  logic                    at_last;

  // Element (r,c) sits (NELEM-1-(r*rCol+c)) element slots above bit 0.
  function automatic logic [elemWidth-1:0] elem_at(
    input logic [matrixRLen-1:0] m,
    input logic [idxWidth-1:0]   r,
    input logic [idxWidth-1:0]   c
  );
    int unsigned lin;
    lin = 32'(r) * NCOL + 32'(c);
    return elemWidth'(m >> ((NELEM - 1 - lin) * EW));
  endfunction

  assign xfer    = valid_q && out_ready;
  assign at_last = valid_q && (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Next index and the element it selects are precomputed so out_data can
  // stay a plain register that only changes on a transfer.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    data_d = '0;
    if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
    if (!at_last) begin
      data_d = elem_at(shadow_q, row_d, col_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            shadow_q <= res_in;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= elem_at(res_in, '0, '0);
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (at_last) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              data_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
              state_q <= DONE;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              data_q <= data_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = at_last;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;

  localparam int R = 4;
  localparam int C = 2;
  localparam int W = 8;
  localparam int N = R * C;
  localparam int L = N * W;

  logic         clk;
  logic         rst;
  logic [L-1:0] res_in;
  logic         load;
  logic         busy;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_row;
  logic [3:0]   out_col;
  logic         out_last;
  logic         done;

  int checks = 0;
  int errors = 0;

  matrix_result_streamer #(
    .rRow(R),
    .rCol(C),
    .elemWidth(W),
    .matrixRLen(L),
    .idxWidth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .res_in(res_in),
    .load(load),
    .busy(busy),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_col(out_col),
    .out_last(out_last),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [L-1:0] rand_matrix();
    return {$urandom, $urandom};
  endfunction

  // Runs one full matrix through the DUT starting from an idle negedge and
  // ends on the following idle negedge. mode: 0 ready always, 1 ready pattern
  // 1,0,0 repeating, 2 random ready. mid_k: pulse load with all-ones while
  // element mid_k is presented. abort_k: assert reset after abort_k transfers.
  task automatic run_stream(input logic [L-1:0] m, input int mode,
                            input int mid_k, input int abort_k);
    logic [W-1:0] exp_q[$];
    logic [L-1:0] mm;
    int k;
    int cyc;
    int pat;
    bit rdy;
    mm  = m;
    k   = 0;
    cyc = 0;
    pat = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(mm[L-1-i*W -: W]);

    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_load busy=%b valid=%b done=%b required 0 0 0", busy, out_valid, done);
    end
    res_in    = mm;
    load      = 1'b1;
    out_ready = 1'b0;

    while (k < N && cyc < 100) begin
      @(negedge clk);
      cyc++;
      load   = 1'b0;
      res_in = rand_matrix();
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
          errors++;
          $display("FAIL async_reset valid=%b busy=%b done=%b data=%0h required all 0",
                   out_valid, busy, done, out_data);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold done=%b valid=%b required 0 0", done, out_valid);
          end
        end
        out_ready = 1'b0;
        rst = 1'b1;
        return;
      end
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stream_flags k=%0d valid=%b busy=%b done=%b required 1 1 0",
                 k, out_valid, busy, done);
      end
      checks++;
      if (out_data !== exp_q[k]) begin
        errors++;
        $display("FAIL data k=%0d got %0d required %0d", k, out_data, exp_q[k]);
      end
      checks++;
      if (out_row !== 4'(k / C) || out_col !== 4'(k % C)) begin
        errors++;
        $display("FAIL index k=%0d got (%0d,%0d) required (%0d,%0d)",
                 k, out_row, out_col, k / C, k % C);
      end
      checks++;
      if (out_last !== (k == N - 1)) begin
        errors++;
        $display("FAIL last k=%0d got %b required %b", k, out_last, (k == N - 1));
      end
      if (k == mid_k) begin
        load   = 1'b1;
        res_in = '1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pat % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pat++;
      out_ready = rdy;
      if (rdy) k++;
    end

    checks++;
    if (k < N) begin
      errors++;
      $display("FAIL stream_timeout transfers=%0d required %0d", k, N);
    end

    // DONE cycle: a load here must be ignored.
    @(negedge clk);
    out_ready = 1'($urandom_range(0, 1));
    load      = 1'b1;
    res_in    = rand_matrix();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle done=%b busy=%b valid=%b last=%b required 1 1 0 0",
               done, busy, out_valid, out_last);
    end

    @(negedge clk);
    load      = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b busy=%b valid=%b required 0 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    res_in    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== '0 ||
        out_row !== '0 || out_col !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b valid=%b done=%b data=%0h row=%0d col=%0d last=%b required all 0",
               busy, out_valid, done, out_data, out_row, out_col, out_last);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_stream({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_stream({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 1, -1, -1);
    run_stream(rand_matrix(), 2, -1, -1);
  endtask

  task automatic test_load_ignored();
    run_stream({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 0, 3, -1);
    run_stream(rand_matrix(), 2, 5, -1);
    run_stream(rand_matrix(), 0, N - 1, -1);
    run_stream('1, 0, -1, -1);
  endtask

  task automatic test_input_change();
    run_stream(rand_matrix(), 0, -1, -1);
    run_stream(rand_matrix(), 2, -1, -1);
  endtask

  task automatic test_async_reset();
    run_stream({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 0, -1, 3);
    run_stream({8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88}, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_stream({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 0, -1, -1);
    run_stream({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 0, -1, -1);
    for (int i = 0; i < 5; i++) run_stream(rand_matrix(), 2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_ignored();
    test_input_change();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
